// File: rtl/spi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_fifo
// Brief    : SPI slave with RX/TX FIFOs, run-time CPOL/CPHA/bit order and a
//            CPU register map with sticky W1C status and per-bit IRQ enables.
// Revision : 1.0 - initial release
// ============================================================================

module spi_slave_fifo_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_wr_en;
    logic             w_rd_en;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign w_wr_en = push_i && !full_o;
    assign w_rd_en = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_wr_en) wptr_q <= wptr_q + 1'b1;
            if (w_rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module spi_slave_fifo #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_FILL    = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] data_from_cpu,
    output logic [31:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic [2:0]            sclk_q, ss_q;
    logic [1:0]            mosi_q;
    logic [2:0]            mode_q, mode_d;      // {lsbfirst, cpha, cpol} of the current frame
    logic [2:0]            ctrl_mode_q;
    logic [6:0]            ctrl_en_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  primed_q, primed_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [3:0]            flags_q, flags_d;    // {abort, tur, toe, roe}
    logic [31:0]           data_to_cpu_q;
    logic                  irq_q;

    logic w_rd, w_wr, w_rx_pop, w_tx_push, w_stat_wr, w_ctrl_wr, w_rx_flush, w_tx_flush;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_active;
    logic w_sample_edge, w_shift_edge, w_tx_load, w_word_done, w_tmt;
    logic [CW-1:0]         w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_rx_next, w_load_word, w_rx_head, w_tx_head;
    logic [AW:0]           w_rx_level, w_tx_level;
    logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic [31:0]           w_status, w_rdata;
    logic unused_ok;

    assign unused_ok = ^data_from_cpu;

    assign w_rd       = spi_select && !read_n;
    assign w_wr       = spi_select && !write_n;
    assign w_rx_pop   = w_rd && (mem_addr == 3'd0);
    assign w_tx_push  = w_wr && (mem_addr == 3'd1);
    assign w_stat_wr  = w_wr && (mem_addr == 3'd2);
    assign w_ctrl_wr  = w_wr && (mem_addr == 3'd3);
    assign w_rx_flush = w_ctrl_wr && data_from_cpu[11];
    assign w_tx_flush = w_ctrl_wr && data_from_cpu[12];

    assign w_sclk_rise   = sclk_q[1] && !sclk_q[2];
    assign w_sclk_fall   = !sclk_q[1] && sclk_q[2];
    assign w_ss_fall     = !ss_q[1] && ss_q[2];
    assign w_ss_rise     = ss_q[1] && !ss_q[2];
    assign w_active      = !ss_q[1] && !ss_q[2];
    assign w_sample_edge = w_active && ((mode_q[0] == mode_q[1]) ? w_sclk_rise : w_sclk_fall);
    assign w_shift_edge  = w_active && ((mode_q[0] == mode_q[1]) ? w_sclk_fall : w_sclk_rise);

    // A counter of zero on a non-primed shift edge marks a word boundary inside the frame
    assign w_tx_load   = w_ss_fall || (w_shift_edge && !primed_q && (cnt_q == '0));
    assign w_load_word = w_tx_empty ? TX_FILL : w_tx_head;
    assign w_cnt_inc   = cnt_q + 1'b1;
    assign w_word_done = w_sample_edge && (w_cnt_inc == CW'(DATA_WIDTH));
    assign w_rx_next   = mode_q[2] ? {mosi_q[1], rx_sh_q[DATA_WIDTH-1:1]}
                                   : {rx_sh_q[DATA_WIDTH-2:0], mosi_q[1]};
    assign w_tmt       = w_tx_empty && ss_q[1];

    spi_slave_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .flush_i(w_rx_flush), .push_i(w_word_done),
        .pop_i(w_rx_pop), .wdata_i(w_rx_next), .head_o(w_rx_head),
        .level_o(w_rx_level), .full_o(w_rx_full), .empty_o(w_rx_empty)
    );

    spi_slave_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .flush_i(w_tx_flush), .push_i(w_tx_push),
        .pop_i(w_tx_load), .wdata_i(data_from_cpu[DATA_WIDTH-1:0]), .head_o(w_tx_head),
        .level_o(w_tx_level), .full_o(w_tx_full), .empty_o(w_tx_empty)
    );

    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        rx_sh_d  = rx_sh_q;
        tx_sh_d  = tx_sh_q;
        if (w_ss_fall) begin
            mode_d   = ctrl_mode_q;
            cnt_d    = '0;
            primed_d = ctrl_mode_q[1];
            tx_sh_d  = w_load_word;
        end else if (w_ss_rise) begin
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (w_sample_edge) begin
            rx_sh_d = w_rx_next;
            cnt_d   = w_word_done ? '0 : w_cnt_inc;
        end else if (w_shift_edge) begin
            if (primed_q)
                primed_d = 1'b0;
            else if (cnt_q == '0)
                tx_sh_d = w_load_word;
            else
                tx_sh_d = mode_q[2] ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        end
    end

    always_comb begin
        flags_d = flags_q & ~(w_stat_wr ? data_from_cpu[6:3] : 4'b0000);
        flags_d = flags_d | {w_ss_rise && (cnt_q != '0),
                             w_tx_load && w_tx_empty,
                             w_tx_push && w_tx_full,
                             w_word_done && w_rx_full};
    end

    assign w_status = {8'd0, 8'(w_tx_level), 8'(w_rx_level), |flags_q, flags_q,
                       w_tmt, !w_tx_full, !w_rx_empty};

    always_comb begin
        w_rdata = 32'd0;
        case (mem_addr)
            3'd0:    w_rdata = w_rx_empty ? 32'd0 : 32'(w_rx_head);
            3'd2:    w_rdata = w_status;
            3'd3:    w_rdata = {21'd0, ctrl_mode_q, 1'b0, ctrl_en_q};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q        <= 3'b000;
            ss_q          <= 3'b111;
            mosi_q        <= 2'b00;
            mode_q        <= 3'b000;
            ctrl_mode_q   <= 3'b000;
            ctrl_en_q     <= 7'd0;
            cnt_q         <= '0;
            primed_q      <= 1'b0;
            rx_sh_q       <= '0;
            tx_sh_q       <= '0;
            flags_q       <= 4'd0;
            data_to_cpu_q <= 32'd0;
            irq_q         <= 1'b0;
        end else begin
            sclk_q   <= {sclk_q[1:0], SCLK};
            ss_q     <= {ss_q[1:0], SS_n};
            mosi_q   <= {mosi_q[0], MOSI};
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            rx_sh_q  <= rx_sh_d;
            tx_sh_q  <= tx_sh_d;
            flags_q  <= flags_d;
            irq_q    <= |(w_status[6:0] & ctrl_en_q);
            if (w_ctrl_wr) begin
                ctrl_en_q   <= data_from_cpu[6:0];
                ctrl_mode_q <= data_from_cpu[10:8];
            end
            if (w_rd) data_to_cpu_q <= w_rdata;
        end
    end

    assign data_to_cpu = data_to_cpu_q;
    assign irq         = irq_q;
    assign MISO        = !SS_n && (mode_q[2] ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]);
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_fifo
// Brief    : Randomised bench for spi_slave_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_fifo;
    localparam int          W     = 16;
    localparam int          DEPTH = 8;
    localparam int          H     = 60;
    localparam logic [15:0] TXF   = 16'h0000;

    logic clk = 1'b0, reset = 1'b0, spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
    logic [2:0] mem_addr = 3'd0;
    logic [31:0] data_from_cpu = 32'd0, data_to_cpu;
    logic irq, MISO, SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;

    int n_checks = 0, n_pass = 0;
    logic [15:0] tx_q[$], rx_q[$], frame_miso[$];
    bit m_roe, m_toe, m_tur, m_abort;
    bit cur_cpol, cur_cpha, cur_lsb;
    int word_idx;

    spi_slave_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .TX_FILL(TXF)) dut (
        .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
        .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        logic [3:0] f;
        f = {m_abort, m_tur, m_toe, m_roe};
        return {8'd0, 8'(tx_q.size()), 8'(rx_q.size()), |f, f,
                tx_q.size() == 0, tx_q.size() < DEPTH, rx_q.size() != 0};
    endfunction

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); spi_select = 1; mem_addr = a; write_n = 0; data_from_cpu = d;
        @(negedge clk); spi_select = 0; write_n = 1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk); spi_select = 1; mem_addr = a; read_n = 0;
        @(negedge clk); spi_select = 0; read_n = 1; d = data_to_cpu;
    endtask

    task automatic m_tx_push(input logic [15:0] d);
        cpu_write(3'd1, {16'd0, d});
        if (tx_q.size() == DEPTH) m_toe = 1; else tx_q.push_back(d);
    endtask

    task automatic m_tx_pop(output logic [15:0] w);
        if (tx_q.size() == 0) begin w = TXF; m_tur = 1; end
        else w = tx_q.pop_front();
    endtask

    task automatic clear_flags();
        cpu_write(3'd2, 32'h78);
        m_roe = 0; m_toe = 0; m_tur = 0; m_abort = 0;
    endtask

    task automatic set_mode(input bit cpol, input bit cpha, input bit lsb, input logic [6:0] en);
        cur_cpol = cpol; cur_cpha = cpha; cur_lsb = lsb;
        SCLK = cpol;
        cpu_write(3'd3, {21'd0, lsb, cpha, cpol, 1'b0, en});
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_low();
        logic [15:0] w;
        SS_n = 0; word_idx = 0; frame_miso.delete();
        m_tx_pop(w); frame_miso.push_back(w);
        #(2*H);
    endtask

    task automatic ss_high(input bit partial);
        #(2*H); SS_n = 1;
        if (partial) m_abort = 1;
        #(2*H);
    endtask

    // Master side of one word; words after the first pop TX at their leading edge
    // (CPHA=1), and every completed word pops TX again at its last trailing edge (CPHA=0).
    task automatic spi_word(input logic [15:0] mo, input int nbits,
                            output logic [15:0] got, output logic [15:0] exp);
        logic [15:0] w;
        got = '0;
        if (cur_cpha && word_idx > 0) begin m_tx_pop(w); frame_miso.push_back(w); end
        exp = frame_miso[word_idx];
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = cur_lsb ? i : W - 1 - i;
            if (!cur_cpha) begin
                MOSI = mo[b]; #H; got[b] = MISO; SCLK = ~SCLK; #H; SCLK = ~SCLK;
            end else begin
                SCLK = ~SCLK; MOSI = mo[b]; #H; got[b] = MISO; SCLK = ~SCLK; #H;
            end
        end
        if (nbits == W) begin
            if (rx_q.size() == DEPTH) m_roe = 1; else rx_q.push_back(mo);
            if (!cur_cpha) begin m_tx_pop(w); frame_miso.push_back(w); end
        end
        word_idx++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1; repeat (2) @(negedge clk); reset = 0;
        @(posedge clk); #1;
        n_checks++; if (data_to_cpu !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", data_to_cpu); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
        n_checks++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", MISO); else n_pass++;
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== 32'h6) $display("FAIL reset_status: got %h expected 00000006", rd); else n_pass++;
        cpu_read(3'd3, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", rd); else n_pass++;
        cpu_read(3'd0, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL reset_rx_empty: got %h expected 0", rd); else n_pass++;
    endtask

    task automatic test_single_word(input bit cpol, input bit cpha, input bit lsb,
                                    input logic [15:0] txw, input logic [15:0] mo);
        logic [15:0] got, exp;
        logic [31:0] rd;
        clear_flags();
        set_mode(cpol, cpha, lsb, 7'd0);
        m_tx_push(txw);
        ss_low(); spi_word(mo, W, got, exp); ss_high(0);
        n_checks++; if (got !== exp) $display("FAIL word_miso m%0d%0d l%0d: got %h expected %h", cpol, cpha, lsb, got, exp); else n_pass++;
        n_checks++; if (MISO !== 1'b0) $display("FAIL miso_idle: got %b expected 0", MISO); else n_pass++;
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL word_status: got %h expected %h", rd, exp_status()); else n_pass++;
        cpu_read(3'd0, rd); exp = rx_q.pop_front();
        n_checks++; if (rd !== {16'd0, exp}) $display("FAIL word_rx: got %h expected %h", rd, exp); else n_pass++;
    endtask

    task automatic test_mode3_burst();
        logic [15:0] got, exp, mo[3];
        logic [31:0] rd;
        clear_flags();
        set_mode(1, 1, 1, 7'd0);
        for (int i = 0; i < 3; i++) m_tx_push(16'($urandom));
        ss_low();
        for (int i = 0; i < 3; i++) begin
            mo[i] = 16'($urandom);
            spi_word(mo[i], W, got, exp);
            n_checks++; if (got !== exp) $display("FAIL burst_miso%0d: got %h expected %h", i, got, exp); else n_pass++;
        end
        ss_high(0);
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL burst_status: got %h expected %h", rd, exp_status()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cpu_read(3'd0, rd); exp = rx_q.pop_front();
            n_checks++; if (rd !== {16'd0, exp}) $display("FAIL burst_rx%0d: got %h expected %h", i, rd, exp); else n_pass++;
        end
    endtask

    task automatic test_underflow_irq();
        logic [15:0] got, exp;
        logic [31:0] rd;
        bit seen;
        clear_flags();
        set_mode(0, 0, 0, 7'h20);
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) $display("FAIL tur_irq_idle: got %b expected 0", irq); else n_pass++;
        @(negedge clk); ss_low_nowait();
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) $display("FAIL tur_irq_rise: got 0 expected 1 within 8 clk"); else n_pass++;
        #(2*H);
        spi_word(16'($urandom), W, got, exp);
        ss_high(0);
        n_checks++; if (got !== exp) $display("FAIL tur_miso: got %h expected %h", got, exp); else n_pass++;
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL tur_status: got %h expected %h", rd, exp_status()); else n_pass++;
        @(negedge clk); spi_select = 1; mem_addr = 3'd2; write_n = 0; data_from_cpu = 32'h20;
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b1) $display("FAIL tur_irq_hold: got %b expected 1", irq); else n_pass++;
        @(negedge clk); spi_select = 0; write_n = 1; m_tur = 0;
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) $display("FAIL tur_irq_drop: got %b expected 0", irq); else n_pass++;
        cpu_read(3'd0, rd); exp = rx_q.pop_front();
        n_checks++; if (rd !== {16'd0, exp}) $display("FAIL tur_rx: got %h expected %h", rd, exp); else n_pass++;
    endtask

    task automatic ss_low_nowait();
        logic [15:0] w;
        SS_n = 0; word_idx = 0; frame_miso.delete();
        m_tx_pop(w); frame_miso.push_back(w);
    endtask

    task automatic test_rx_overflow();
        logic [15:0] got, exp;
        logic [31:0] rd;
        int m;
        clear_flags();
        m = $urandom_range(0, 3);
        set_mode(m[1], m[0], 1'($urandom), 7'd0);
        ss_low();
        for (int i = 0; i < DEPTH + 1; i++) spi_word(16'($urandom), W, got, exp);
        ss_high(0);
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL rxovf_status: got %h expected %h", rd, exp_status()); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(3'd0, rd); exp = rx_q.pop_front();
            n_checks++; if (rd !== {16'd0, exp}) $display("FAIL rxovf_rx%0d: got %h expected %h", i, rd, exp); else n_pass++;
        end
        cpu_read(3'd0, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rxovf_empty_read: got %h expected 0", rd); else n_pass++;
    endtask

    task automatic test_tx_overflow();
        logic [15:0] got, exp, a_word;
        logic [31:0] rd, rd2;
        clear_flags();
        set_mode(0, 0, 0, 7'd0);
        for (int i = 0; i < DEPTH + 1; i++) m_tx_push(16'($urandom));
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL txovf_status: got %h expected %h", rd, exp_status()); else n_pass++;
        cpu_write(3'd3, 32'h1000); tx_q.delete();
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL txflush_status: got %h expected %h", rd, exp_status()); else n_pass++;
        cpu_read(3'd3, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL txflush_ctrl: got %h expected 0", rd); else n_pass++;
        ss_low(); spi_word(16'($urandom), W, got, exp); ss_high(0);
        a_word = rx_q[0];
        ss_low();
        fork
            spi_word(16'($urandom), W, got, exp);
            begin #((2*W - 1)*H + 10); cpu_read(3'd0, rd2); end
        join
        ss_high(0);
        void'(rx_q.pop_front());
        n_checks++; if (rd2 !== {16'd0, a_word}) $display("FAIL popush_rx: got %h expected %h", rd2, a_word); else n_pass++;
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL popush_status: got %h expected %h", rd, exp_status()); else n_pass++;
        cpu_read(3'd0, rd); exp = rx_q.pop_front();
        n_checks++; if (rd !== {16'd0, exp}) $display("FAIL popush_rx2: got %h expected %h", rd, exp); else n_pass++;
    endtask

    task automatic test_abort();
        logic [15:0] got, exp;
        logic [31:0] rd;
        int m;
        clear_flags();
        m = $urandom_range(0, 3);
        set_mode(m[1], m[0], 1'($urandom), 7'd0);
        m_tx_push(16'($urandom));
        ss_low(); spi_word(16'($urandom), 5, got, exp); ss_high(1);
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL abort_status: got %h expected %h", rd, exp_status()); else n_pass++;
        m_tx_push(16'($urandom));
        ss_low(); spi_word(16'($urandom), W, got, exp); ss_high(0);
        n_checks++; if (got !== exp) $display("FAIL abort_next_miso: got %h expected %h", got, exp); else n_pass++;
        cpu_read(3'd0, rd); exp = rx_q.pop_front();
        n_checks++; if (rd !== {16'd0, exp}) $display("FAIL abort_next_rx: got %h expected %h", rd, exp); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] got, exp;
        logic [31:0] rd;
        set_mode(0, 0, 0, 7'h02);
        m_tx_push(16'($urandom));
        ss_low(); spi_word(16'($urandom), 5, got, exp);
        cpu_read(3'd2, rd);
        n_checks++; if (irq !== 1'b1) $display("FAIL midrst_irq_before: got %b expected 1", irq); else n_pass++;
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        n_checks++; if (data_to_cpu !== 32'd0) $display("FAIL midrst_rdata: got %h expected 0", data_to_cpu); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL midrst_irq: got %b expected 0", irq); else n_pass++;
        n_checks++; if (MISO !== 1'b0) $display("FAIL midrst_miso: got %b expected 0", MISO); else n_pass++;
        @(negedge clk); reset = 0; SS_n = 1; SCLK = 0; MOSI = 0;
        tx_q.delete(); rx_q.delete();
        m_roe = 0; m_toe = 0; m_tur = 0; m_abort = 0;
        repeat (3) @(negedge clk);
        cpu_read(3'd2, rd);
        n_checks++; if (rd !== exp_status()) $display("FAIL midrst_status: got %h expected %h", rd, exp_status()); else n_pass++;
        cpu_read(3'd3, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL midrst_ctrl: got %h expected 0", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word(0, 0, 0, 16'hA5C3, 16'h1234);
        test_single_word(1, 1, 1, 16'($urandom), 16'h00F1);
        for (int i = 0; i < 4; i++) begin
            int m;
            m = $urandom_range(0, 3);
            test_single_word(m[1], m[0], 1'($urandom), 16'($urandom), 16'($urandom));
        end
        test_mode3_burst();
        test_underflow_irq();
        test_rx_overflow();
        test_tx_overflow();
        test_abort();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
- Parametrised next-generation SPI slave peripheral on the Qsys CPU bus.
- Word width is configurable; SPI mode (CPOL/CPHA) and bit order are set at run time.
- RX and TX FIFOs replace the single holding registers.
- Adds back-to-back multi-word frames, underflow/abort detection, write-1-to-clear status and per-bit IRQ enables.

Parameters:
- DATA_WIDTH, 16: bits per SPI word; legal range 4..32.
- FIFO_DEPTH, 8: entries in each of RX and TX FIFO; power of two, 2..128.
- TX_FILL, 0: word shifted out on TX underflow; DATA_WIDTH bits.

Ports:
- clk  in  1  system clock; SCLK frequency must be ≤ clk/8.
- reset  in  1  synchronous, active-high reset.
- spi_select  in  1  chip select for register access.
- mem_addr  in  3  register address.
- read_n  in  1  active-low read; each clk cycle it is low with spi_select high is one access.
- write_n  in  1  active-low write; one access per cycle, same rule as read_n.
- data_from_cpu  in  32  write data.
- data_to_cpu  out  32  read data, registered; valid the cycle after the access.
- irq  out  1  registered interrupt.
- SCLK  in  1  SPI clock, asynchronous.
- SS_n  in  1  SPI slave select, active low, asynchronous.
- MOSI  in  1  SPI data in, asynchronous.
- MISO  out  1  SPI data out; 0 when SS_n is high.

Behaviour:
- Reset (synchronous, active-high, held 1 clk minimum):
  - FIFOs empty; all sticky flags 0; control = 0; irq = 0; data_to_cpu = 0; MISO = 0.
  - Bit counter 0; synchronizers preset to SCLK=CPOL and SS_n=1.
- Register map (unused bits read 0):
  - 0 RX data: read pops one RX word, zero-extended. Read when empty returns 0, no pop, no error.
  - 1 TX data: write pushes data_from_cpu[DATA_WIDTH-1:0]. Write when full is dropped and sets TOE.
  - 2 status:
    - Bit [0] RRDY = RX not empty.
    - Bit [1] TRDY = TX not full.
    - Bit [2] TMT = TX empty and SS_n idle.
    - Bit [3] ROE, sticky.
    - Bit [4] TOE, sticky.
    - Bit [5] TUR (TX underflow), sticky.
    - Bit [6] ABORT, sticky.
    - Bit [7] E = ROE|TOE|TUR|ABORT.
    - Bits [15:8] RX level; bits [23:16] TX level.
    - Write: bits [6:3] are write-1-to-clear.
  - 3 control:
    - Bits [6:0] IRQ enables, one per status bit [6:0].
    - Bit [8] CPOL; bit [9] CPHA; bit [10] LSBFIRST.
    - Bit [11] RX flush and bit [12] TX flush: write-only, self-clearing, empty the FIFO in the same cycle and read back as 0.
- irq = registered OR over (status[6:0] & enable[6:0]); 1 clk latency.
- SPI synchronization:
  - SCLK, SS_n and MOSI each pass through a 2-FF synchronizer.
  - Edges are detected against a 3rd stage.
- Mode latch: CPOL, CPHA and LSBFIRST are latched at the synchronized SS_n fall. Control writes during a frame take effect at the next frame.
- Edge roles: sample edge = SCLK rising when CPOL==CPHA, else falling. Shift edge = the opposite edge.
- SS_n fall (frame start):
  - Pop TX head into the shift register. If TX is empty, load TX_FILL and set TUR.
  - Bit counter = 0; primed = CPHA.
- Sample edge:
  - Shift in MOSI, at the LSB end when MSB-first, else at the MSB end.
  - Increment the counter.
  - When the counter reaches DATA_WIDTH, wrap it to 0 and push the shift-in word to RX.
  - If RX is full, drop the word and set ROE.
  - A CPU pop and an SPI push in the same cycle both take effect.
- Shift edge (first matching rule applies):
  - If primed: clear primed, no shift.
  - Else if counter == 0: load the next TX word, with the same underflow rule as frame start. This gives back-to-back words within one SS_n-low frame.
  - Else: advance the output bit.
- MISO drives the current output bit (MSB or LSB per the latched mode) while the raw SS_n is low, else 0.
- SS_n rise with counter ≠ 0 (mid-word): discard the partial word, set ABORT, reset the counter. The TX word already popped is lost.
- SCLK edges while SS_n is high are ignored.

Test Plan:
- Mode 0, DATA_WIDTH=16: CPU pushes 0xA5C3; master sends 0x1234 MSB-first -> MISO stream 0xA5C3; RX word 0x1234; RRDY=1; status[15:8]=1.
- Mode 3 with LSBFIRST=1: master sends 0x00F1 -> RX reads 0x00F1. Then 3 words in one SS_n-low frame with TX pushed 1,2,3 -> MISO carries 1,2,3; RX level 3.
- TX empty at frame start with TX_FILL=0 -> MISO all 0; TUR=1. With enable bit 5 set, irq=1 two clk after the SS_n fall. Writing status 0x20 -> TUR=0 and irq drops 1 clk later.
- RX overflow: FIFO_DEPTH=8, master sends 9 words without CPU reads -> level 8; ROE=1; first 8 words intact in order.
- TX overflow: push 9 words -> TOE=1; TX level 8; TRDY=0. The same-cycle RX pop plus SPI push leaves the level unchanged.
- Abort: SS_n rises after 5 bits -> ABORT=1; RX unchanged. The next full frame is received correctly. Reset asserted mid-frame -> all reset values next clk.
